shiftreg_sequencer: RTL and testbench

SHIFTREG_SEQUENCER -- requirements
Module: shiftreg_sequencer

---
 rtl/shiftreg_pkg.sv | 27 ++
 rtl/sr_bitclk.sv | 40 ++++
 rtl/shiftreg_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_shiftreg_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg
// Shared definitions for the shift-register load sequencer:
//   - state_t      : sequencer state enumeration
//   - DEF_STAT_W   : default static chain length in bits
//   - DEF_DYN_W    : default dynamic chain length in bits
//   - DEF_CLK_DIV  : default CLK cycles per serial bit
//   - maxOf()      : elaboration-time helper for sizing counters
package shiftreg_pkg;

  localparam int DEF_STAT_W  = 88;
  localparam int DEF_DYN_W   = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_STAT,
    LATCH_STAT,
    SHIFT_DYN,
    LATCH_DYN,
    DONE
  } state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_bitclk.sv
// sr_bitclk
// Serial bit timing generator. While i_run is high it divides the system
// clock into bit slots of CLK_DIV cycles; each slot starts with SCLK low for
// CLK_DIV/2 cycles and ends with SCLK high for the remaining cycles.
// Ports:
//   i_clk     in   system clock
//   i_rst_n   in   asynchronous active-low reset
//   i_run     in   slot counter runs while high, held at slot start while low
//   o_sclk    out  serial clock phase for the current slot
//   o_bitEnd  out  high on the last CLK cycle of a slot
module sr_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_sclk,
  output logic o_bitEnd
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_phase;

  // Phase counter wraps at the end of every slot so back-to-back phases of
  // the sequencer (shift -> latch -> shift) line up without a gap cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (!i_run || o_bitEnd) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign o_sclk   = i_run && (r_phase >= CW'(CLK_DIV / 2));
  assign o_bitEnd = i_run && (r_phase == CW'(CLK_DIV - 1));

endmodule

// File: rtl/shiftreg_sequencer.sv
// shiftreg_sequencer
// Loads a static and a dynamic serial shift-register chain. The static word
// comes from a shadow register written at any time; the dynamic word comes
// through a one-entry handshake buffer and may be streamed repeatedly.
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   stat_data, stat_wr     static word and shadow write strobe
//   dyn_data, dyn_valid    dynamic word offer
//   dyn_ready              dynamic buffer empty
//   start, dyn_only        begin a sequence, optionally skipping the static phase
//   SCLK, SDATA            serial clock and data
//   SELSTAT, SELDYN        chain select during shifting
//   STATLATCH, DYNLATCH    chain latch strobes
//   ENFIN                  one-cycle sequence-complete pulse
//   busy                   sequence in progress
module shiftreg_sequencer
  import shiftreg_pkg::*;
#(
  parameter int STAT_W    = DEF_STAT_W,
  parameter int DYN_W     = DEF_DYN_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [STAT_W-1:0] stat_data,
  input  logic              stat_wr,
  input  logic [DYN_W-1:0]  dyn_data,
  input  logic              dyn_valid,
  output logic              dyn_ready,
  input  logic              start,
  input  logic              dyn_only,
  output logic              SCLK,
  output logic              SDATA,
  output logic              SELSTAT,
  output logic              SELDYN,
  output logic              STATLATCH,
  output logic              DYNLATCH,
  output logic              ENFIN,
  output logic              busy
);

  localparam int CNT_W = $clog2(maxOf(STAT_W, DYN_W) + 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [STAT_W-1:0] r_statShadow;
  logic [STAT_W-1:0] r_statShift;
  logic [DYN_W-1:0]  r_dynBuf;
  logic [DYN_W-1:0]  r_dynShift;
  logic              r_dynFull;
  logic [CNT_W-1:0]  r_bitCnt;

  logic w_sclk;
  logic w_bitEnd;
  logic w_run;
  logic w_inShift;
  logic w_accept;
  logic w_dynAvail;
  logic w_lastBit;
  logic w_loadStat;
  logic w_loadDyn;
  logic w_statBit;
  logic w_dynBit;

  assign w_inShift = (r_state == SHIFT_STAT) || (r_state == SHIFT_DYN);
  assign w_run     = w_inShift || (r_state == LATCH_STAT) || (r_state == LATCH_DYN);
  assign w_accept  = dyn_valid && !r_dynFull;
  // A word accepted on the same edge counts as available, so it is not lost
  // when a sequence decides to enter the dynamic phase on that edge.
  assign w_dynAvail = r_dynFull || w_accept;
  assign w_lastBit  = (r_state == SHIFT_STAT) ? (r_bitCnt == CNT_W'(STAT_W - 1))
                                              : (r_bitCnt == CNT_W'(DYN_W - 1));

  sr_bitclk #(
    .CLK_DIV(CLK_DIV)
  ) u_bitclk (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_run   (w_run),
    .o_sclk  (w_sclk),
    .o_bitEnd(w_bitEnd)
  );

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decision. Latch phases reuse the bit timer, so they end on
  // the same bit-end tick that closes a shift slot.
  always_comb begin
    w_nextState = r_state;
    w_loadStat  = 1'b0;
    w_loadDyn   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (!dyn_only) begin
            w_nextState = SHIFT_STAT;
            w_loadStat  = 1'b1;
          end else if (w_dynAvail) begin
            w_nextState = SHIFT_DYN;
            w_loadDyn   = 1'b1;
          end
        end
      end
      SHIFT_STAT: begin
        if (w_bitEnd && w_lastBit) begin
          w_nextState = LATCH_STAT;
        end
      end
      SHIFT_DYN: begin
        if (w_bitEnd && w_lastBit) begin
          w_nextState = LATCH_DYN;
        end
      end
      LATCH_STAT, LATCH_DYN: begin
        if (w_bitEnd) begin
          if (w_dynAvail) begin
            w_nextState = SHIFT_DYN;
            w_loadDyn   = 1'b1;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Static shadow and dynamic handshake buffer. When the dynamic shifter is
  // loaded the buffer always ends up empty: either its word moved out, or a
  // word offered into an empty buffer went straight to the shifter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_statShadow <= '0;
      r_dynBuf     <= '0;
      r_dynFull    <= 1'b0;
    end else begin
      if (stat_wr) begin
        r_statShadow <= stat_data;
      end
      if (w_loadDyn) begin
        r_dynFull <= 1'b0;
      end else if (w_accept) begin
        r_dynBuf  <= dyn_data;
        r_dynFull <= 1'b1;
      end
    end
  end

  // Shifters and bit counter. The static shifter snapshots the shadow at
  // start, so later shadow writes only affect the next sequence.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_statShift <= '0;
      r_dynShift  <= '0;
      r_bitCnt    <= '0;
    end else begin
      if (w_loadStat) begin
        r_statShift <= r_statShadow;
      end else if ((r_state == SHIFT_STAT) && w_bitEnd) begin
        r_statShift <= (MSB_FIRST != 0) ? (r_statShift << 1) : (r_statShift >> 1);
      end
      if (w_loadDyn) begin
        r_dynShift <= r_dynFull ? r_dynBuf : dyn_data;
      end else if ((r_state == SHIFT_DYN) && w_bitEnd) begin
        r_dynShift <= (MSB_FIRST != 0) ? (r_dynShift << 1) : (r_dynShift >> 1);
      end
      if (!w_inShift) begin
        r_bitCnt <= '0;
      end else if (w_bitEnd) begin
        r_bitCnt <= w_lastBit ? '0 : r_bitCnt + 1'b1;
      end
    end
  end

  assign w_statBit = (MSB_FIRST != 0) ? r_statShift[STAT_W-1] : r_statShift[0];
  assign w_dynBit  = (MSB_FIRST != 0) ? r_dynShift[DYN_W-1] : r_dynShift[0];

  assign SCLK      = w_inShift && w_sclk;
  assign SDATA     = (r_state == SHIFT_STAT) ? w_statBit :
                     (r_state == SHIFT_DYN)  ? w_dynBit  : 1'b0;
  assign SELSTAT   = (r_state == SHIFT_STAT);
  assign SELDYN    = (r_state == SHIFT_DYN);
  assign STATLATCH = (r_state == LATCH_STAT);
  assign DYNLATCH  = (r_state == LATCH_DYN);
  assign ENFIN     = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign dyn_ready = !r_dynFull;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// tb_shiftreg_sequencer
// Two sequencers (MSB-first and LSB-first) share one stimulus stream. A
// cycle-schedule model predicts every output each cycle; directed sequences
// pin the model with hand-computed bit patterns and phase lengths, then a
// randomized run with occasional resets exercises the rest.
module tb_shiftreg_sequencer;

  localparam int SW = 8;
  localparam int DW = 4;
  localparam int CD = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [SW-1:0] stat_data = '0;
  logic          stat_wr = 1'b0;
  logic [DW-1:0] dyn_data = '0;
  logic          dyn_valid = 1'b0;
  logic          start = 1'b0;
  logic          dyn_only = 1'b0;

  logic mReady, mSclk, mSdata, mSelS, mSelD, mSLatch, mDLatch, mEnfin, mBusy;
  logic lReady, lSclk, lSdata, lSelS, lSelD, lSLatch, lDLatch, lEnfin, lBusy;

  int checks = 0;
  int failures = 0;

  shiftreg_sequencer #(
    .STAT_W(SW), .DYN_W(DW), .CLK_DIV(CD), .MSB_FIRST(1)
  ) dutMsb (
    .CLK(CLK), .RST_N(RST_N), .stat_data(stat_data), .stat_wr(stat_wr),
    .dyn_data(dyn_data), .dyn_valid(dyn_valid), .dyn_ready(mReady),
    .start(start), .dyn_only(dyn_only), .SCLK(mSclk), .SDATA(mSdata),
    .SELSTAT(mSelS), .SELDYN(mSelD), .STATLATCH(mSLatch), .DYNLATCH(mDLatch),
    .ENFIN(mEnfin), .busy(mBusy)
  );

  shiftreg_sequencer #(
    .STAT_W(SW), .DYN_W(DW), .CLK_DIV(CD), .MSB_FIRST(0)
  ) dutLsb (
    .CLK(CLK), .RST_N(RST_N), .stat_data(stat_data), .stat_wr(stat_wr),
    .dyn_data(dyn_data), .dyn_valid(dyn_valid), .dyn_ready(lReady),
    .start(start), .dyn_only(dyn_only), .SCLK(lSclk), .SDATA(lSdata),
    .SELSTAT(lSelS), .SELDYN(lSelD), .STATLATCH(lSLatch), .DYNLATCH(lDLatch),
    .ENFIN(lEnfin), .busy(lBusy)
  );

  always #5 CLK = ~CLK;

  // One entry per expected CLK cycle of a running sequence; an empty
  // schedule means the sequencer is idle.
  typedef struct packed {
    logic sclk;
    logic sdMsb;
    logic sdLsb;
    logic selS;
    logic selD;
    logic sLatch;
    logic dLatch;
    logic enfin;
    logic decide;
  } cyc_t;

  cyc_t          sched[$];
  logic [SW-1:0] mdlShadow;
  logic [DW-1:0] mdlBuf;
  logic          mdlFull;
  logic          mdlAcc;
  logic          mdlTook;
  cyc_t          mdlHead;
  cyc_t          expC;

  logic [15:0] capM = '0;
  logic [15:0] capL = '0;
  int          capCnt = 0;
  int          cntSL = 0;
  int          cntDL = 0;
  int          cntEn = 0;
  int          cntBusy = 0;
  logic        prevSclk = 1'b0;

  int baseCap, baseSL, baseDL, baseEn, baseBusy;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mVec();
    return {mSclk, mSdata, mSelS, mSelD, mSLatch, mDLatch, mEnfin, mBusy, mReady};
  endfunction

  function automatic logic [8:0] lVec();
    return {lSclk, lSdata, lSelS, lSelD, lSLatch, lDLatch, lEnfin, lBusy, lReady};
  endfunction

  // Appends one shift phase of n bits followed by its latch phase.
  task automatic pushSeg(input logic [SW-1:0] w, input int n, input logic isStat);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < CD; p++) begin
        c = '0;
        c.sclk  = (p >= CD / 2);
        c.sdMsb = w[n-1-i];
        c.sdLsb = w[i];
        c.selS  = isStat;
        c.selD  = !isStat;
        sched.push_back(c);
      end
    end
    for (int p = 0; p < CD; p++) begin
      c = '0;
      c.sLatch = isStat;
      c.dLatch = !isStat;
      c.decide = (p == CD - 1);
      sched.push_back(c);
    end
  endtask

  task automatic pushDone();
    cyc_t c;
    c = '0;
    c.enfin = 1'b1;
    sched.push_back(c);
  endtask

  // Reference model: consumes one scheduled cycle per edge and extends the
  // schedule whenever a latch phase finishes or a start is accepted.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sched.delete();
      mdlShadow = '0;
      mdlBuf    = '0;
      mdlFull   = 1'b0;
    end else begin
      mdlAcc  = dyn_valid && !mdlFull;
      mdlTook = 1'b0;
      if (sched.size() != 0) begin
        mdlHead = sched.pop_front();
        if (mdlHead.decide) begin
          if (mdlFull || mdlAcc) begin
            pushSeg({{(SW-DW){1'b0}}, (mdlFull ? mdlBuf : dyn_data)}, DW, 1'b0);
            mdlTook = 1'b1;
          end else begin
            pushDone();
          end
        end
      end else if (start) begin
        if (!dyn_only) begin
          pushSeg(mdlShadow, SW, 1'b1);
        end else if (mdlFull || mdlAcc) begin
          pushSeg({{(SW-DW){1'b0}}, (mdlFull ? mdlBuf : dyn_data)}, DW, 1'b0);
          mdlTook = 1'b1;
        end
      end
      if (mdlTook) begin
        mdlFull = 1'b0;
      end else if (mdlAcc) begin
        mdlBuf  = dyn_data;
        mdlFull = 1'b1;
      end
      if (stat_wr) begin
        mdlShadow = stat_data;
      end
    end
  end

  // Compare both DUTs against the model every cycle and record the bits the
  // slave would sample plus phase lengths for the directed checks.
  always @(negedge CLK) begin
    if (sched.size() != 0) begin
      expC = sched[0];
    end else begin
      expC = '0;
    end
    checkOutput("msb_outputs", 16'(mVec()),
                16'({expC.sclk, expC.sdMsb, expC.selS, expC.selD, expC.sLatch,
                     expC.dLatch, expC.enfin, (sched.size() != 0), !mdlFull}));
    checkOutput("lsb_outputs", 16'(lVec()),
                16'({expC.sclk, expC.sdLsb, expC.selS, expC.selD, expC.sLatch,
                     expC.dLatch, expC.enfin, (sched.size() != 0), !mdlFull}));
    if (mSclk && !prevSclk) begin
      capM = {capM[14:0], mSdata};
      capL = {capL[14:0], lSdata};
      capCnt++;
    end
    prevSclk = mSclk;
    if (mSLatch) cntSL++;
    if (mDLatch) cntDL++;
    if (mEnfin) cntEn++;
    if (mBusy) cntBusy++;
  end

  // Drives one cycle of inputs, then returns strobes to idle just after the edge.
  task automatic applyStimulus(input logic swr, input logic [SW-1:0] sd, input logic dv,
                               input logic [DW-1:0] dd, input logic st, input logic donly);
    stat_wr   = swr;
    stat_data = sd;
    dyn_valid = dv;
    dyn_data  = dd;
    start     = st;
    dyn_only  = donly;
    @(posedge CLK);
    #1;
    stat_wr   = 1'b0;
    dyn_valid = 1'b0;
    start     = 1'b0;
    dyn_only  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic snapMon();
    baseCap  = capCnt;
    baseSL   = cntSL;
    baseDL   = cntDL;
    baseEn   = cntEn;
    baseBusy = cntBusy;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n;
    n = 0;
    while (mBusy && n < maxCycles) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput({name, "_terminates"}, 16'(mBusy), 16'h0);
  endtask

  // Phase-length checks shared by the directed sequences.
  task automatic checkPhases(input string name, input int bits, input int sl, input int dl,
                             input int en, input int bz);
    checkOutput({name, "_bitcount"}, 16'(capCnt - baseCap), 16'(bits));
    checkOutput({name, "_statlatch"}, 16'(cntSL - baseSL), 16'(sl));
    checkOutput({name, "_dynlatch"}, 16'(cntDL - baseDL), 16'(dl));
    checkOutput({name, "_enfin"}, 16'(cntEn - baseEn), 16'(en));
    checkOutput({name, "_busy"}, 16'(cntBusy - baseBusy), 16'(bz));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_msb", 16'(mVec()), 16'h001);
    checkOutput("reset_lsb", 16'(lVec()), 16'h001);
    RST_N = 1'b1;
    idleCycles(2);

    // Static A5 then dynamic 3.
    applyStimulus(1'b1, 8'hA5, 1'b1, 4'h3, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    waitIdle("t1", 60);
    checkOutput("t1_msb_bits", 16'(capM[11:0]), 16'hA53);
    checkOutput("t1_lsb_bits", 16'(capL[11:0]), 16'hA5C);
    checkPhases("t1", 12, 2, 2, 1, 29);
    idleCycles(2);

    // Empty buffer: static phase only.
    applyStimulus(1'b1, 8'h1E, 1'b0, '0, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    waitIdle("t2", 60);
    checkOutput("t2_msb_bits", 16'(capM[7:0]), 16'h1E);
    checkOutput("t2_lsb_bits", 16'(capL[7:0]), 16'h78);
    checkPhases("t2", 8, 2, 0, 1, 19);
    idleCycles(2);

    // Dynamic-only streaming of C then 5.
    applyStimulus(1'b0, '0, 1'b1, 4'hC, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 4'h5, 1'b0, 1'b0);
    waitIdle("t3", 60);
    checkOutput("t3_msb_bits", 16'(capM[7:0]), 16'hC5);
    checkOutput("t3_lsb_bits", 16'(capL[7:0]), 16'h3A);
    checkPhases("t3", 8, 0, 4, 1, 21);
    idleCycles(2);

    // Shadow write during a shift only affects the next sequence.
    applyStimulus(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, '0, 1'b0, 1'b0);
    waitIdle("t4a", 60);
    checkOutput("t4a_bits", 16'(capM[7:0]), 16'h00);
    checkPhases("t4a", 8, 2, 0, 1, 19);
    idleCycles(1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    waitIdle("t4b", 60);
    checkOutput("t4b_bits", 16'(capM[7:0]), 16'hFF);
    idleCycles(2);

    // Reset at the start of static bit 5 with a dynamic word buffered.
    applyStimulus(1'b1, 8'hA5, 1'b1, 4'h9, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("t5_reset_msb", 16'(mVec()), 16'h001);
    checkOutput("t5_reset_lsb", 16'(lVec()), 16'h001);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idleCycles(6);
    checkOutput("t5_idle_after", 16'(mVec()), 16'h001);
    checkOutput("t5_partial_bits", 16'(capM[4:0]), 16'h14);
    checkPhases("t5", 5, 0, 0, 0, 10);

    // LSB-first instance on static 01.
    applyStimulus(1'b1, 8'h01, 1'b0, '0, 1'b0, 1'b0);
    snapMon();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    waitIdle("t6", 60);
    checkOutput("t6_lsb_bits", 16'(capL[7:0]), 16'h80);
    checkOutput("t6_msb_bits", 16'(capM[7:0]), 16'h01);
    idleCycles(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        RST_N = 1'b0;
      end
      applyStimulus($urandom_range(0, 7) == 0, SW'($urandom), $urandom_range(0, 3) == 0,
                    DW'($urandom), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      RST_N = 1'b1;
    end
    idleCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
